// File: rtl/rs422_frame_pkg.sv
// Shared constants, types and helpers for the RS422 response-frame transmitter.
package rs422_frame_pkg;

  localparam logic [7:0] FRAME_HDR0 = 8'hAA;
  localparam logic [7:0] FRAME_HDR1 = 8'h55;
  localparam logic [7:0] FRAME_TAIL = 8'hEF;
  localparam int         FRAME_LEN  = 9;

  typedef enum logic [1:0] {
    F_IDLE,
    F_LEAD,
    F_SEND,
    F_TAIL
  } frame_state_e;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_phase_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [31:0] data;
    logic [7:0]  chk;
  } frame_fields_t;

  function automatic logic [7:0] frame_xor(input logic [7:0] cmd, input logic [31:0] data);
    return cmd ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

  // Wire order: AA 55 CMD D3 D2 D1 D0 XOR EF
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input frame_fields_t f);
    case (idx)
      4'd0:    return FRAME_HDR0;
      4'd1:    return FRAME_HDR1;
      4'd2:    return f.cmd;
      4'd3:    return f.data[31:24];
      4'd4:    return f.data[23:16];
      4'd5:    return f.data[15:8];
      4'd6:    return f.data[7:0];
      4'd7:    return f.chk;
      default: return FRAME_TAIL;
    endcase
  endfunction

endpackage

// File: rtl/rs422_frame_tx_if.sv
// Request/status handshake between a frame producer and the RS422 frame transmitter.
interface rs422_frame_tx_if;

  logic        tx_req;
  logic [7:0]  tx_cmd;
  logic [31:0] tx_data;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output tx_req, tx_cmd, tx_data,
    input  tx_busy, tx_done
  );

  modport slave (
    input  tx_req, tx_cmd, tx_data,
    output tx_busy, tx_done
  );

endinterface

// File: rtl/rs422_frame_tx_uart_tx_byte.sv
// 8N1 byte serialiser, LSB first; a load on the last stop-bit cycle chains the
// next start bit with no idle gap.
module uart_tx_byte
  import rs422_frame_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  output logic       byte_end,
  output logic       di
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

  uart_phase_e   phase, phase_nxt;
  logic [CW-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          di_nxt;
  logic          bit_end;
  logic          ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clkin) begin
    if (rst) begin
      phase    <= U_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      di       <= 1'b1;
    end else begin
      phase    <= phase_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      di       <= di_nxt;
    end
  end

  assign bit_end  = (phase != U_IDLE) && (baud_cnt == BAUD_LAST);
  assign byte_end = (phase == U_STOP) && bit_end;
  assign ready    = (phase == U_IDLE) || byte_end;

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    phase_nxt    = phase;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    if (load && ready) begin
      phase_nxt    = U_START;
      baud_cnt_nxt = '0;
      bit_idx_nxt  = '0;
      shift_nxt    = tx_byte;
    end else if (phase != U_IDLE) begin
      if (!bit_end) begin
        baud_cnt_nxt = baud_cnt + 1'b1;
      end else begin
        baud_cnt_nxt = '0;
        case (phase)
          U_START: phase_nxt = U_DATA;
          U_DATA: begin
            // shift[0] always holds the bit currently on the wire
            shift_nxt = shift >> 1;
            if (bit_idx == 3'd7) phase_nxt   = U_STOP;
            else                 bit_idx_nxt = bit_idx + 1'b1;
          end
          default: phase_nxt = U_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (phase_nxt)
      U_START: di_nxt = 1'b0;
      U_DATA:  di_nxt = shift_nxt[0];
      default: di_nxt = 1'b1;
    endcase
  end

endmodule

// File: rtl/rs422_frame_tx.sv
// RS422 response-frame transmitter: frame FSM, byte mux, XOR checksum and
// driver-enable guard timing around the 8N1 serialiser.
module rs422_frame_tx
  import rs422_frame_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int DE_LEAD = 16,
  parameter int DE_TAIL = 16
) (
  input  logic             clkin,
  input  logic             rst,
  rs422_frame_tx_if.slave  tx,
  output logic             rs422_di_main,
  output logic             rs422_de_main,
  output logic             rs422_re_n_main
);

  localparam int            GUARD_MAX = (DE_LEAD > DE_TAIL) ? DE_LEAD : DE_TAIL;
  localparam int            GW        = $clog2(GUARD_MAX + 1);
  localparam logic [GW-1:0] LEAD_LAST = GW'(DE_LEAD - 1);
  localparam logic [GW-1:0] TAIL_DROP = GW'(DE_TAIL - 1);
  localparam logic [GW-1:0] TAIL_LAST = GW'(DE_TAIL);
  localparam logic [3:0]    LAST_IDX  = 4'(FRAME_LEN - 1);

  frame_state_e  state, state_nxt;
  logic [GW-1:0] guard_cnt, guard_cnt_nxt;
  logic [3:0]    byte_idx, byte_idx_nxt;
  frame_fields_t fields, fields_nxt;
  logic          de, de_nxt;
  logic          busy, busy_nxt;
  logic          done, done_nxt;
  logic          load;
  logic [3:0]    load_idx;
  logic [7:0]    load_byte;
  logic          uart_byte_end;

  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= F_IDLE;
      guard_cnt <= '0;
      byte_idx  <= '0;
      fields    <= '0;
      de        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
      byte_idx  <= byte_idx_nxt;
      fields    <= fields_nxt;
      de        <= de_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // TAIL holds one cycle past the DE release so a request coinciding with
  // tx_done still sees a non-idle FSM and is dropped.
  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    byte_idx_nxt  = byte_idx;
    fields_nxt    = fields;
    case (state)
      F_IDLE: begin
        if (tx.tx_req) begin
          state_nxt     = F_LEAD;
          guard_cnt_nxt = '0;
          byte_idx_nxt  = '0;
          fields_nxt    = '{cmd:  tx.tx_cmd,
                            data: tx.tx_data,
                            chk:  frame_xor(tx.tx_cmd, tx.tx_data)};
        end
      end
      F_LEAD: begin
        if (guard_cnt == LEAD_LAST) begin
          state_nxt    = F_SEND;
          byte_idx_nxt = '0;
        end else begin
          guard_cnt_nxt = guard_cnt + 1'b1;
        end
      end
      F_SEND: begin
        if (uart_byte_end) begin
          if (byte_idx == LAST_IDX) begin
            state_nxt     = F_TAIL;
            guard_cnt_nxt = '0;
          end else begin
            byte_idx_nxt = byte_idx + 1'b1;
          end
        end
      end
      F_TAIL: begin
        if (guard_cnt == TAIL_LAST) state_nxt     = F_IDLE;
        else                        guard_cnt_nxt = guard_cnt + 1'b1;
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    load_idx = byte_idx + 1'b1;
    de_nxt   = de;
    busy_nxt = busy;
    done_nxt = 1'b0;
    case (state)
      F_IDLE: begin
        if (tx.tx_req) begin
          de_nxt   = 1'b1;
          busy_nxt = 1'b1;
        end
      end
      F_LEAD: begin
        if (guard_cnt == LEAD_LAST) begin
          load     = 1'b1;
          load_idx = '0;
        end
      end
      F_SEND: begin
        if (uart_byte_end && (byte_idx != LAST_IDX)) load = 1'b1;
      end
      F_TAIL: begin
        if (guard_cnt == TAIL_DROP) begin
          de_nxt   = 1'b0;
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
    load_byte = frame_byte(load_idx, fields);
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_uart (
    .clkin    (clkin),
    .rst      (rst),
    .load     (load),
    .tx_byte  (load_byte),
    .byte_end (uart_byte_end),
    .di       (rs422_di_main)
  );

  // Receiver is blanked exactly while the driver is enabled
  assign rs422_de_main   = de;
  assign rs422_re_n_main = de;
  assign tx.tx_busy      = busy;
  assign tx.tx_done      = done;

endmodule

// File: tb/tb_rs422_frame_tx.sv
// Self-checking bench for rs422_frame_tx: table vectors, corner sequences,
// random frames against a timeline/UART-decoder model, and a full-rate timing run.
module tb_rs422_frame_tx;

  localparam int D_A   = 8;
  localparam int L_A   = 4;
  localparam int T_A   = 4;
  localparam int TOT_A = L_A + 90 * D_A + T_A;
  localparam int D_B   = 434;
  localparam int L_B   = 16;
  localparam int T_B   = 16;
  localparam int TOT_B = L_B + 90 * D_B + T_B;

  typedef logic [7:0] byte_arr_t [9];
  typedef struct {
    string       name;
    logic [7:0]  cmd;
    logic [31:0] data;
    byte_arr_t   exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  rs422_frame_tx_if ifa ();
  rs422_frame_tx_if ifb ();
  logic di_a, de_a, ren_a, di_b, de_b, ren_b;

  rs422_frame_tx #(.CLK_DIV(D_A), .DE_LEAD(L_A), .DE_TAIL(T_A)) dut_a (
    .clkin           (clk),
    .rst             (rst),
    .tx              (ifa),
    .rs422_di_main   (di_a),
    .rs422_de_main   (de_a),
    .rs422_re_n_main (ren_a)
  );

  rs422_frame_tx #(.CLK_DIV(D_B), .DE_LEAD(L_B), .DE_TAIL(T_B)) dut_b (
    .clkin           (clk),
    .rst             (rst),
    .tx              (ifb),
    .rs422_di_main   (di_b),
    .rs422_de_main   (de_b),
    .rs422_re_n_main (ren_b)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         ren_bad  = 0;
  logic [7:0] rx_q[$];
  logic       stop_q[$];
  vec_t       vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte_arr_t model_frame(input logic [7:0] cmd, input logic [31:0] data);
    byte_arr_t  f;
    logic [7:0] x;
    f[0] = 8'hAA;
    f[1] = 8'h55;
    f[2] = cmd;
    for (int i = 0; i < 4; i++) f[3 + i] = data[31 - 8 * i -: 8];
    x = 8'h00;
    for (int i = 2; i <= 6; i++) x ^= f[i];
    f[7] = x;
    f[8] = 8'hEF;
    return f;
  endfunction

  // Expected line level k cycles after the acceptance edge of a D_A frame
  function automatic logic exp_di(input int k, input byte_arr_t bytes);
    int j;
    if (k < L_A || k >= L_A + 90 * D_A) return 1'b1;
    j = (k - L_A) / D_A;
    if (j % 10 == 0) return 1'b0;
    if (j % 10 == 9) return 1'b1;
    return bytes[j / 10][j % 10 - 1];
  endfunction

  // UART receiver on dut_a's line: mid-bit sampling, 8N1, LSB first
  initial begin : uart_rx_model
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (!rst && di_a === 1'b0) begin
        repeat (D_A / 2) @(negedge clk);
        ok = (di_a === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (D_A) @(negedge clk);
          b[i] = di_a;
        end
        repeat (D_A) @(negedge clk);
        ok = ok && (di_a === 1'b1);
        rx_q.push_back(b);
        stop_q.push_back(ok);
      end
    end
  end

  always @(negedge clk) if (ren_a !== de_a || ren_b !== de_b) ren_bad++;

  task automatic run_frame(input string name, input logic [7:0] cmd, input logic [31:0] data,
                           input byte_arr_t exp, input int inject_k, input bit chain,
                           input logic [7:0] next_cmd, input logic [31:0] next_data);
    int   bad, first_bad, low_k, fall_k, quiet, stops;
    logic e_di, e_de, e_done;
    bad = 0; first_bad = -1; low_k = -1; fall_k = -1; stops = 0;
    rx_q.delete();
    stop_q.delete();
    ifa.tx_req  = 1'b1;
    ifa.tx_cmd  = cmd;
    ifa.tx_data = data;
    tick();
    ifa.tx_req  = 1'b0;
    ifa.tx_cmd  = 8'($urandom);
    ifa.tx_data = $urandom;
    for (int k = 0; k <= TOT_A; k++) begin
      e_de   = (k < TOT_A);
      e_done = (k == TOT_A);
      e_di   = exp_di(k, exp);
      if (di_a !== e_di || de_a !== e_de || ren_a !== e_de ||
          ifa.tx_busy !== e_de || ifa.tx_done !== e_done) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (low_k < 0 && di_a === 1'b0) low_k = k;
      if (fall_k < 0 && de_a === 1'b0) fall_k = k;
      if (k == inject_k) begin
        ifa.tx_req  = 1'b1;
        ifa.tx_cmd  = 8'hFF;
        ifa.tx_data = 32'hFFFF_FFFF;
      end else begin
        ifa.tx_req = 1'b0;
      end
      if (chain && k == TOT_A) begin
        ifa.tx_req  = 1'b1;
        ifa.tx_cmd  = next_cmd;
        ifa.tx_data = next_data;
      end
      if (k < TOT_A) tick();
    end
    check($sformatf("%s timeline (first bad k=%0d)", name, first_bad), bad, 0);
    check({name, " de lead before start"}, low_k, L_A);
    check({name, " de tail after stop"}, fall_k - (L_A + 90 * D_A), T_A);
    check({name, " rx byte count"}, rx_q.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s byte %0d", name, i), (i < rx_q.size()) ? 64'(rx_q[i]) : 64'hFFFF, exp[i]);
    foreach (stop_q[i]) if (stop_q[i]) stops++;
    check({name, " stop bits"}, stops, 9);
    tick();
    if (chain) begin
      check({name, " req on tx_done ignored"}, {de_a, ifa.tx_busy}, 2'b00);
    end else begin
      quiet = 0;
      for (int i = 0; i < 10; i++) begin
        if (de_a !== 1'b0 || ifa.tx_done !== 1'b0) quiet++;
        tick();
      end
      check({name, " idle after frame"}, quiet, 0);
    end
  endtask

  initial begin
    int          quiet, dones;
    logic [7:0]  rc;
    logic [31:0] rd;
    logic        prev_di;
    real         t_acc, t_fall1, t_rise1, t_fall2, t_defall, w;

    vecs[0].name = "spec1"; vecs[0].cmd = 8'h05; vecs[0].data = 32'h0303_0001;
    vecs[0].exp  = '{8'hAA, 8'h55, 8'h05, 8'h03, 8'h03, 8'h00, 8'h01, 8'h04, 8'hEF};
    vecs[1].name = "spec2"; vecs[1].cmd = 8'h07; vecs[1].data = 32'h0000_0000;
    vecs[1].exp  = '{8'hAA, 8'h55, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'hEF};
    vecs[2].name = "mixed"; vecs[2].cmd = 8'h5A; vecs[2].data = 32'h1234_5678;
    vecs[2].exp  = '{8'hAA, 8'h55, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h52, 8'hEF};
    vecs[3].name = "ones";  vecs[3].cmd = 8'hFF; vecs[3].data = 32'hFFFF_FFFF;
    vecs[3].exp  = '{8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF};

    rst = 1'b1;
    ifa.tx_req = 1'b0; ifa.tx_cmd = '0; ifa.tx_data = '0;
    ifb.tx_req = 1'b0; ifb.tx_cmd = '0; ifb.tx_data = '0;
    repeat (3) tick();
    check("reset A di/de/re_n", {di_a, de_a, ren_a}, 3'b100);
    check("reset A busy/done", {ifa.tx_busy, ifa.tx_done}, 2'b00);
    check("reset B di/de/re_n", {di_b, de_b, ren_b}, 3'b100);
    check("reset B busy/done", {ifb.tx_busy, ifb.tx_done}, 2'b00);
    rst = 1'b0;
    repeat (2) tick();

    foreach (vecs[i])
      run_frame(vecs[i].name, vecs[i].cmd, vecs[i].data, vecs[i].exp, -1, 1'b0, 8'h00, 32'h0);

    // Request with FFFFFFFF in the middle of byte 3 must be dropped
    run_frame("midreq", vecs[0].cmd, vecs[0].data, vecs[0].exp, L_A + 30 * D_A + 5, 1'b0, 8'h00, 32'h0);

    // Back-to-back: req on the tx_done cycle is dropped, held one more cycle it is taken
    run_frame("b2b_first", vecs[2].cmd, vecs[2].data, vecs[2].exp, -1, 1'b1, vecs[3].cmd, vecs[3].data);
    run_frame("b2b_second", vecs[3].cmd, vecs[3].data, vecs[3].exp, -1, 1'b0, 8'h00, 32'h0);

    // Reset in the middle of byte 4 aborts the frame
    ifa.tx_req = 1'b1; ifa.tx_cmd = vecs[2].cmd; ifa.tx_data = vecs[2].data;
    tick();
    ifa.tx_req = 1'b0;
    repeat (L_A + 40 * D_A + 15) tick();
    check("abort precondition busy", ifa.tx_busy, 1'b1);
    rst = 1'b1;
    tick();
    check("abort di/de/re_n", {di_a, de_a, ren_a}, 3'b100);
    check("abort busy/done", {ifa.tx_busy, ifa.tx_done}, 2'b00);
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 12 * D_A; i++) begin
      if (de_a !== 1'b0 || di_a !== 1'b1 || ifa.tx_busy !== 1'b0) quiet++;
      tick();
    end
    check("abort line quiet", quiet, 0);
    run_frame("after_reset", vecs[0].cmd, vecs[0].data, vecs[0].exp, -1, 1'b0, 8'h00, 32'h0);

    for (int r = 0; r < 6; r++) begin
      rc = 8'($urandom);
      rd = $urandom;
      run_frame($sformatf("rand%0d cmd=%02h data=%08h", r, rc, rd), rc, rd,
                model_frame(rc, rd), -1, 1'b0, 8'h00, 32'h0);
    end

    // Full-rate instance: absolute timing at 50 MHz / 434
    ifb.tx_req = 1'b1; ifb.tx_cmd = 8'h00; ifb.tx_data = 32'h0;
    tick();
    ifb.tx_req = 1'b0;
    check("B de at accept", {de_b, ren_b, ifb.tx_busy}, 3'b111);
    t_acc = $realtime;
    t_fall1 = -1.0; t_rise1 = -1.0; t_fall2 = -1.0; t_defall = -1.0;
    dones = 0;
    prev_di = di_b;
    for (int k = 0; k < TOT_B + 20; k++) begin
      if (prev_di === 1'b1 && di_b === 1'b0) begin
        if (t_fall1 < 0.0)      t_fall1 = $realtime;
        else if (t_fall2 < 0.0) t_fall2 = $realtime;
      end
      if (prev_di === 1'b0 && di_b === 1'b1 && t_rise1 < 0.0) t_rise1 = $realtime;
      if (t_defall < 0.0 && de_b === 1'b0) t_defall = $realtime;
      if (ifb.tx_done === 1'b1) dones++;
      prev_di = di_b;
      tick();
    end
    w = t_fall2 - t_rise1;
    check($sformatf("B bit width %0.1f ns in 8680+/-20", w),
          (t_rise1 > 0.0 && t_fall2 > 0.0 && w >= 8660.0 && w <= 8700.0), 1'b1);
    w = t_defall - T_B * 20.0 - t_fall1;
    check($sformatf("B frame %0.1f ns in 781200+/-20", w),
          (t_fall1 > 0.0 && t_defall > 0.0 && w >= 781180.0 && w <= 781220.0), 1'b1);
    w = t_fall1 - t_acc;
    check($sformatf("B de lead %0.1f ns = 320", w), (w >= 319.0 && w <= 321.0), 1'b1);
    check("B tx_done pulses", dones, 1);

    check("re_n tracks de", ren_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
